// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with mid-bit sampling.
// Bytes are handed over through a valid/ack handshake.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 10,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       rx_ack_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state, state_n;
  logic          sync1, rx_s, rx_p;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    data_n;
  logic          valid_n, ferr_n, ovr_n;
  logic          tick;

  assign tick   = (cnt == '0);
  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1       <= 1'b1;
      rx_s        <= 1'b1;
      rx_p        <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      sync1       <= rx_i;
      rx_s        <= sync1;
      rx_p        <= rx_s;
      state       <= state_n;
      cnt         <= cnt_n;
      bit_cnt     <= bit_n;
      shift       <= shift_n;
      rx_data_o   <= data_n;
      rx_valid_o  <= valid_n;
      frame_err_o <= ferr_n;
      overrun_o   <= ovr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = tick ? cnt : cnt - 1'b1;
    bit_n   = bit_cnt;
    shift_n = shift;
    data_n  = rx_data_o;
    valid_n = rx_valid_o & ~rx_ack_i;
    ferr_n  = 1'b0;
    ovr_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_p && !rx_s) begin
          bit_n   = '0;
          cnt_n   = HALF_M1;
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            cnt_n   = BIT_M1;
            state_n = DATA;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_n = {rx_s, shift[7:1]};
          cnt_n   = BIT_M1;
          bit_n   = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            // a same-cycle ack lets the new byte in without overrun
            data_n  = shift;
            valid_n = 1'b1;
            ovr_n   = rx_valid_o & ~rx_ack_i;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
